// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the multiply/divide unit.
//
// Accepts MDU instructions from the E stage. For an arithmetic op it issues a
// start pulse to the engine, latches the op and counts the fixed latency. It
// then emits a one-cycle HI/LO commit pulse, which is suppressed for divide by
// zero. MTHI/MTLO become same-cycle write enables. The block also raises the
// D-stage stall for MDU-related instructions while an operation is in flight.
//
// Parameters:
//   MULT_LAT  issue-to-commit cycles for MULT/MULTU (2..15)
//   DIV_LAT   issue-to-commit cycles for DIV/DIVU   (2..15)
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   e_valid      E-stage instruction valid and not flushed
//   e_op         E-stage MDU op (0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE)
//   e_div_zero   divisor operand is zero, qualified by e_op
//   d_md         D-stage instruction is an MDU-related instruction
//   start        one-cycle issue pulse to engine
//   eng_op       op latched at issue, stable while busy
//   busy         operation in flight (registered)
//   commit       engine result writes {HI,LO} at the end of this cycle
//   hi_we/lo_we  MTHI/MTLO write enables
//   stall_d      stall D and freeze F/D
//   state        debug FSM state: 0 IDLE, 1 MUL, 2 DIV
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [2:0] e_op,
  input  logic       e_div_zero,
  input  logic       d_md,
  output logic       start,
  output logic [2:0] eng_op,
  output logic       busy,
  output logic       commit,
  output logic       hi_we,
  output logic       lo_we,
  output logic       stall_d,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [2:0] eng_op_r;
  logic       zflag_r;
  logic       busy_r;

  logic       is_arith_s;
  logic       is_div_s;
  logic       start_s;
  logic       last_s;

  // Decode the E-stage op and derive the combinational control outputs.
  always_comb begin
    is_arith_s = 1'b0;
    is_div_s   = 1'b0;
    start_s    = 1'b0;
    last_s     = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    if ((e_op >= 3'd1) && (e_op <= 3'd4)) begin
      is_arith_s = 1'b1;
    end else begin
      is_arith_s = 1'b0;
    end
    if ((e_op == 3'd3) || (e_op == 3'd4)) begin
      is_div_s = 1'b1;
    end else begin
      is_div_s = 1'b0;
    end
    // An arithmetic op arriving while busy is ignored; stall_d keeps it out.
    start_s = e_valid && is_arith_s && (state_r == ST_IDLE);
    hi_we   = e_valid && (e_op == 3'd5) && !busy_r;
    lo_we   = e_valid && (e_op == 3'd6) && !busy_r;
    // Final cycle of an operation: counter has reached one.
    if ((state_r != ST_IDLE) && (cnt_r == 4'd1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  assign start   = start_s;
  assign commit  = last_s && !zflag_r;
  assign stall_d = d_md && (busy_r || start_s);
  assign busy    = busy_r;
  assign eng_op  = eng_op_r;
  assign state   = state_r;

  // Sequencing FSM: issue, latency countdown and return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      eng_op_r <= 3'd0;
      zflag_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            eng_op_r <= e_op;
            zflag_r  <= e_div_zero && is_div_s;
            busy_r   <= 1'b1;
            if (is_div_s) begin
              state_r <= ST_DIV;
              cnt_r   <= DIV_CNT;
            end else begin
              state_r <= ST_MUL;
              cnt_r   <= MULT_CNT;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_r == 4'd1) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the pipelined CPU's multiply/divide datapath. It accepts MDU instructions from the E stage and issues the start pulse and operation to the arithmetic engine. It counts the fixed operation latency and emits the HI/LO commit pulse. It also generates the D-stage stall that keeps later MDU-related instructions (mult/div/mf*/mt*) behind an in-flight operation.

## Interface
Parameters:
- MULT_LAT, 5, cycles from issue to commit for MULT/MULTU; legal range 2..15
- DIV_LAT, 10, cycles from issue to commit for DIV/DIVU; legal range 2..15

Ports:
- Clock and reset: clk, synchronous active-high reset.
  - clk  in  1  clock
  - reset  in  1  synchronous, active-high reset
- e_valid  in  1  E-stage instruction valid and not flushed this cycle
- e_op  in  3  E-stage MDU op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- e_div_zero  in  1  divisor operand == 0, valid with e_op
- d_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- start  out  1  one-cycle issue pulse to engine (combinational)
- eng_op  out  3  op latched at issue, held stable while busy
- busy  out  1  operation in flight (registered)
- commit  out  1  one-cycle pulse: engine result writes {HI,LO} at end of this cycle
- hi_we  out  1  MTHI write enable (combinational)
- lo_we  out  1  MTLO write enable (combinational)
- stall_d  out  1  stall D stage and freeze F/D (combinational)
- state  out  2  FSM state, debug: 0 IDLE, 1 MUL, 2 DIV

## Operation
- FSM states:
  - IDLE: busy=0.
  - MUL: busy=1, counts MULT_LAT.
  - DIV: busy=1, counts DIV_LAT.
- Arithmetic ops are 1–4.
- Issue condition: start = e_valid && op∈{1..4} && state==IDLE.
- At the clock edge where start is high:
  - eng_op <= e_op.
  - cnt <= MULT_LAT or DIV_LAT.
  - state <= MUL or DIV.
  - zflag <= e_div_zero && op∈{3,4}.
- In MUL/DIV, each edge decrements cnt.
- In MUL/DIV, when cnt==1:
  - commit = !zflag.
  - state <= IDLE at that edge.
- Divide by zero: the full DIV_LAT still elapses; commit is suppressed and HI/LO keep their old values.
- MTHI/MTLO:
  - hi_we = e_valid && e_op==5 && !busy.
  - lo_we = e_valid && e_op==6 && !busy.
  - These are single-cycle and never change state.
- stall_d = d_md && (busy || start).
- Because of stall_d, an arithmetic or MT op in E while busy=1 is illegal.
  - Such an op is ignored: no start, no hi_we/lo_we, state unchanged.
  - The bench flags it with an assertion.
- e_valid=0 or e_op∈{0,7}: no action.
- The counter is 4 bits wide and never wraps: it decrements only in MUL/DIV and only while cnt ≥ 1.
- Reset values:
  - state=IDLE, cnt=0, eng_op=0, zflag=0.
  - Outputs: busy=0, commit=0, start=0, hi_we=0, lo_we=0, stall_d=0.
- Reset mid-operation returns to IDLE on that edge. No commit is issued and HI/LO are untouched by this block.

## Timing
- Issue at cycle T (start=1). busy=1 in cycles T+1..T+LAT.
- commit=1 in cycle T+LAT, so HI/LO are written at the end of T+LAT. busy=0 at T+LAT+1.
- stall_d is high in T..T+LAT for any d_md instruction.
- An mfhi/mflo held in D is released at T+LAT+1 and reads the committed HI/LO.
- A new arithmetic op can issue at T+LAT+1 at the earliest (back-to-back interval LAT+1).
- MTHI/MTLO in E with busy=0 write in the same cycle. An mfhi in the following cycle sees the value via the register file/forwarding, not via this block.
- Simultaneous events:
  - Reset has priority over start and commit.
  - A start in the same cycle as a final commit is impossible: state≠IDLE during the commit cycle.

## Test plan
- MULT issue at T=10 (MULT_LAT=5) → busy high 11–15, commit only at 15, state 1→0 at edge end of 15, eng_op=1 stable 11–15.
- DIV with e_div_zero=1, d_md=1 held in D → stall_d high 10–20, commit never pulses, busy falls at 21.
- Back-to-back MULTU then DIVU → second start no earlier than T+6; DIVU commit at T+6+10; no overlapping busy.
- MTHI in E with busy=0 → hi_we=1 for one cycle, start=0, state stays IDLE; MTLO with busy=1 (forced) → lo_we=0, assertion fires.
- Reset asserted at cycle T+3 of a DIV → state=IDLE, busy=0, cnt=0 next cycle, no commit thereafter; fresh MULT afterward commits normally.
- e_valid=0 with e_op=1, and e_op=7 with e_valid=1 → start, hi_we, lo_we and stall_d all stay 0.
